// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ADD/SUB/ADDU/SUBU/ROL/ROR, iterative MUL/DIV,
// valid/ready on both sides, NZCVGQOP flag vector registered with the result.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [7:0]       flags,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] W_VEC = WIDTH'(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_ADDU, OP_SUBU, OP_ROL, OP_ROR, OP_MUL, OP_DIV
  } op_t;

  state_t               state_q, state_d;
  op_t                  op_q;
  logic [WIDTH-1:0]     a_q, b_q;
  logic [SHW-1:0]       cnt_q;
  logic [2*WIDTH-1:0]   p_q, p_nxt;
  logic                 accept, is_iter, last_iter;
  logic [WIDTH-1:0]     s_r, f_r, b_mod;
  logic                 s_c, s_v, f_c, f_v;
  logic [WIDTH:0]       sum, diff, mul_sum;
  logic [WIDTH+1:0]     trial;
  logic [WIDTH-1:0]     rem_n;

  // Flag vector from the final result and the captured operands
  function automatic logic [7:0] mk_flags(input logic [WIDTH-1:0] r, a, b,
                                          input logic c, v);
    logic [SHW:0] pop;
    pop = '0;
    for (int unsigned i = 0; i < WIDTH; i++) pop = pop + (SHW+1)'(r[i]);
    return {r[WIDTH-1], r == '0, c, v, a > b, a == b, r[0],
            pop == (SHW+1)'(WIDTH/2)};
  endfunction

  assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign is_iter   = (opcode == OP_MUL) | (opcode == OP_DIV);
  assign last_iter = (cnt_q == SHW'(WIDTH-1));
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == BUSY);

  // Single-cycle operations, evaluated on the live inputs in the accept cycle
  always_comb begin
    sum   = {1'b0, a_in} + {1'b0, b_in};
    diff  = {1'b0, a_in} - {1'b0, b_in};
    b_mod = b_in % W_VEC;
    s_r   = sum[WIDTH-1:0];
    s_c   = 1'b0;
    s_v   = 1'b0;
    case (op_t'(opcode))
      OP_ADD: begin
        s_r = sum[WIDTH-1:0];
        s_c = sum[WIDTH];
        s_v = (a_in[WIDTH-1] == b_in[WIDTH-1]) & (s_r[WIDTH-1] != a_in[WIDTH-1]);
      end
      OP_SUB: begin
        s_r = diff[WIDTH-1:0];
        s_c = diff[WIDTH];
        s_v = (a_in[WIDTH-1] != b_in[WIDTH-1]) & (s_r[WIDTH-1] != a_in[WIDTH-1]);
      end
      OP_ADDU: begin
        s_c = sum[WIDTH];
        s_r = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
      end
      OP_SUBU: begin
        s_c = diff[WIDTH];
        s_r = diff[WIDTH] ? '0 : diff[WIDTH-1:0];
      end
      // Last bit rotated out lands in R[0] (ROL) or R[MSB] (ROR); an amount
      // of zero leaves A untouched because A >> WIDTH is zero.
      OP_ROL: begin
        s_r = (a_in << b_mod) | (a_in >> (W_VEC - b_mod));
        s_c = (b_mod != '0) & s_r[0];
      end
      OP_ROR: begin
        s_r = (a_in >> b_mod) | (a_in << (W_VEC - b_mod));
        s_c = (b_mod != '0) & s_r[WIDTH-1];
      end
      default: ;
    endcase
  end

  // One MUL (shift-add) or DIV (restoring) step on the shared {hi, lo} register
  always_comb begin
    mul_sum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, a_q} : '0);
    trial   = {1'b0, p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]} - {2'b00, b_q};
    rem_n   = trial[WIDTH+1] ? {p_q[2*WIDTH-2:WIDTH], p_q[WIDTH-1]}
                             : trial[WIDTH-1:0];
    if (op_q == OP_MUL) p_nxt = {mul_sum, p_q[WIDTH-1:1]};
    else                p_nxt = {rem_n, p_q[WIDTH-2:0], ~trial[WIDTH+1]};
    f_r = p_nxt[WIDTH-1:0];
    f_c = (op_q == OP_MUL) & (p_nxt[2*WIDTH-1:WIDTH] != '0);
    f_v = (op_q == OP_DIV) & (b_q == '0);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; DONE can chain directly into a new op when accepting
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = is_iter ? BUSY : DONE;
      BUSY:    if (last_iter) state_d = DONE;
      DONE: begin
        if (accept)         state_d = is_iter ? BUSY : DONE;
        else if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, iteration and result/flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= OP_ADD;
      a_q    <= '0;
      b_q    <= '0;
      cnt_q  <= '0;
      p_q    <= '0;
      result <= '0;
      flags  <= '0;
    end else if (accept) begin
      op_q  <= op_t'(opcode);
      a_q   <= a_in;
      b_q   <= b_in;
      cnt_q <= '0;
      if (opcode == OP_MUL)      p_q <= {{WIDTH{1'b0}}, b_in};
      else if (opcode == OP_DIV) p_q <= {{WIDTH{1'b0}}, a_in};
      else begin
        result <= s_r;
        flags  <= mk_flags(s_r, a_in, b_in, s_c, s_v);
      end
    end else if (state_q == BUSY) begin
      p_q   <= p_nxt;
      cnt_q <= cnt_q + SHW'(1);
      if (last_iter) begin
        result <= f_r;
        flags  <= mk_flags(f_r, a_q, b_q, f_c, f_v);
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=8).
module tb_alu_seq;

  logic       clk, rst_n, in_valid, in_ready, out_valid, out_ready, busy;
  logic [2:0] opcode;
  logic [7:0] a_in, b_in, result, flags;

  int checks = 0;
  int errors = 0;

  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .a_in(a_in), .b_in(b_in), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .flags(flags), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one request at the negedge; returns #1 after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    chk("in_ready_before_issue", 32'(in_ready), 32'd1);
    opcode = op; a_in = a; b_in = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a_in = ~a; b_in = ~b; opcode = ~op;
  endtask

  // Issue, wait (bounded) for out_valid, then check latency, busy span, result, flags.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] er, input logic [7:0] ef,
                        input int lat, input int busy_cyc);
    int cyc;
    int bcnt;
    issue(op, a, b);
    cyc = 1; bcnt = 0;
    while (!out_valid && cyc < 40) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_latency"}, 32'(cyc), 32'(lat));
    chk({tag, "_busy_cycles"}, 32'(bcnt), 32'(busy_cyc));
    chk({tag, "_result"}, 32'(result), 32'(er));
    chk({tag, "_flags"}, 32'(flags), 32'(ef));
  endtask

  initial begin
    logic [2:0] bb_op [3];
    logic [7:0] bb_a [3];
    logic [7:0] bb_b [3];
    logic [7:0] bb_r [3];
    logic [7:0] bb_f [3];
    int stale;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    opcode = '0; a_in = '0; b_in = '0;
    #7;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    rst_n = 1'b1;

    // Single-cycle ops
    run_op("add_7f_01",  3'd0, 8'h7F, 8'h01, 8'h80, 8'h98, 1, 0);
    run_op("addu_f0_20", 3'd2, 8'hF0, 8'h20, 8'hFF, 8'hAA, 1, 0);
    run_op("sub_05_05",  3'd1, 8'h05, 8'h05, 8'h00, 8'h44, 1, 0);
    run_op("sub_03_05",  3'd1, 8'h03, 8'h05, 8'hFE, 8'hA0, 1, 0);
    run_op("subu_03_05", 3'd3, 8'h03, 8'h05, 8'h00, 8'h60, 1, 0);
    run_op("rol_81_01",  3'd4, 8'h81, 8'h01, 8'h03, 8'h2A, 1, 0);
    run_op("ror_01_09",  3'd5, 8'h01, 8'h09, 8'h80, 8'hA0, 1, 0);
    run_op("rol_5a_00",  3'd4, 8'h5A, 8'h00, 8'h5A, 8'h09, 1, 0);

    // Iterative ops
    run_op("mul_10_10",  3'd6, 8'h10, 8'h10, 8'h00, 8'h64, 9, 8);
    run_op("mul_0d_0b",  3'd6, 8'h0D, 8'h0B, 8'h8F, 8'h8A, 9, 8);
    run_op("div_a5_00",  3'd7, 8'hA5, 8'h00, 8'hFF, 8'h9A, 9, 8);

    // DIV with in_valid pulses during BUSY that must be ignored
    issue(3'd7, 8'hC8, 8'h07);
    for (int i = 0; i < 8; i++) begin
      chk("div_busy", 32'(busy), 32'd1);
      chk("div_in_ready_low", 32'(in_ready), 32'd0);
      opcode = 3'd0; a_in = 8'h11; b_in = 8'h22; in_valid = 1'b1;
      #3 in_valid = 1'b0;
      @(posedge clk); #1;
    end
    chk("div_c8_07_valid", 32'(out_valid), 32'd1);
    chk("div_c8_07_result", 32'(result), 32'h1C);
    chk("div_c8_07_flags", 32'(flags), 32'h08);
    @(posedge clk); #1;
    chk("div_pulse_ignored", 32'(out_valid), 32'd0);

    // Output stall: result/flags stay put for 5 cycles
    out_ready = 1'b0;
    issue(3'd0, 8'h7F, 8'h01);
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_result", 32'(result), 32'h80);
      chk("hold_flags", 32'(flags), 32'h98);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("hold_release", 32'(out_valid), 32'd0);

    // Back-to-back ADDs: one result per cycle
    bb_op = '{3'd0, 3'd0, 3'd0};
    bb_a  = '{8'h01, 8'h10, 8'hFF};
    bb_b  = '{8'h02, 8'h20, 8'h01};
    bb_r  = '{8'h03, 8'h30, 8'h00};
    bb_f  = '{8'h02, 8'h00, 8'h68};
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      opcode = bb_op[i]; a_in = bb_a[i]; b_in = bb_b[i]; in_valid = 1'b1;
      @(posedge clk); #1;
      chk("b2b_valid", 32'(out_valid), 32'd1);
      chk("b2b_result", 32'(result), 32'(bb_r[i]));
      chk("b2b_flags", 32'(flags), 32'(bb_f[i]));
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("b2b_drain", 32'(out_valid), 32'd0);

    // Reset in the middle of a DIV: aborted, nothing presented afterwards
    issue(3'd7, 8'hC8, 8'h07);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid || busy) stale++;
    end
    chk("abort_no_stale", 32'(stale), 32'd0);
    run_op("post_abort_add", 3'd0, 8'h01, 8'h02, 8'h03, 8'h02, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
